// File: rtl/apb_cfg_master_pkg.sv
// apb_cfg_master_pkg: register-bus defines, command op and FSM state encodings shared by apb_cfg_master.
`ifndef REG_ADDRWIDTH
`define REG_ADDRWIDTH 8
`endif
`ifndef REG_DATAWIDTH
`define REG_DATAWIDTH 32
`endif
`ifndef REG_ADDR_START
`define REG_ADDR_START 8'h00
`endif
`ifndef REG_ADDR_ENABLES
`define REG_ADDR_ENABLES 8'h04
`endif
`ifndef REG_ADDR_BATCH
`define REG_ADDR_BATCH 8'h08
`endif

package apb_cfg_master_pkg;
    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_POLL  = 2'b10;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETUP  = 3'd1;
    localparam logic [2:0] ST_ACCESS = 3'd2;
    localparam logic [2:0] ST_GAP    = 3'd3;
    localparam logic [2:0] ST_RESP   = 3'd4;

    localparam int CMD_W = 2 + `REG_ADDRWIDTH + `REG_DATAWIDTH;
endpackage

// File: rtl/apb_cfg_master_cmd_fifo.sv
// apb_cfg_master_cmd_fifo: synchronous command FIFO with full/empty flags.
module apb_cfg_master_cmd_fifo #(
    parameter int WIDTH = 42,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wptr, rptr;

    assign empty = wptr == rptr;
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rdata = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push && !full) begin
                mem[wptr[AW-1:0]] <= wdata;
                wptr <= wptr + 1'b1;
            end
            if (pop && !empty) rptr <= rptr + 1'b1;
        end
    end
endmodule

// File: rtl/apb_cfg_master.sv
// apb_cfg_master: queued write/read/poll commands to APB transactions.
// Optional APB_TIMEOUT_EN aborts an ACCESS phase after TIMEOUT_CYCLES without PREADY.
module apb_cfg_master
    import apb_cfg_master_pkg::*;
#(
    parameter int CMD_DEPTH      = 4,
    parameter int POLL_GAP       = 8,
    parameter int POLL_BIT       = 31,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [1:0]                cmd_op,
    input  logic [`REG_ADDRWIDTH-1:0] cmd_addr,
    input  logic [`REG_DATAWIDTH-1:0] cmd_wdata,
    output logic                      rsp_valid,
    output logic [`REG_DATAWIDTH-1:0] rsp_rdata,
    output logic                      rsp_error,
    output logic                      busy,
    output logic [15:0]               poll_count,
    output logic [`REG_ADDRWIDTH-1:0] PADDR,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    output logic [`REG_DATAWIDTH-1:0] PWDATA,
    input  logic [`REG_DATAWIDTH-1:0] PRDATA,
    input  logic                      PREADY
);
    // One counter serves both the poll gap and the access timeout; they never overlap.
    localparam int CMAX = POLL_GAP > TIMEOUT_CYCLES ? POLL_GAP : TIMEOUT_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    logic [2:0] state;
    logic [1:0] op;
    logic [CW-1:0] cnt;
    logic full, empty;
    logic [1:0] f_op;
    logic [`REG_ADDRWIDTH-1:0] f_addr;
    logic [`REG_DATAWIDTH-1:0] f_wdata;

    apb_cfg_master_cmd_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (cmd_valid),
        .pop   (state == ST_IDLE),
        .wdata ({cmd_op, cmd_addr, cmd_wdata}),
        .rdata ({f_op, f_addr, f_wdata}),
        .full  (full),
        .empty (empty)
    );

    assign cmd_ready = !full;
    assign busy      = !empty || state != ST_IDLE;
    assign rsp_valid = state == ST_RESP;

`ifdef APB_TIMEOUT_EN
    logic err;
    assign rsp_error = err;
`else
    assign rsp_error = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            op         <= OP_WRITE;
            cnt        <= '0;
            PADDR      <= '0;
            PWRITE     <= 1'b0;
            PSEL       <= 1'b0;
            PENABLE    <= 1'b0;
            PWDATA     <= '0;
            rsp_rdata  <= '0;
            poll_count <= '0;
`ifdef APB_TIMEOUT_EN
            err        <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: if (!empty) begin
                    op     <= f_op;
                    PADDR  <= f_addr;
                    PWDATA <= f_wdata;
                    PWRITE <= f_op == OP_WRITE;
                    PSEL   <= 1'b1;
                    state  <= ST_SETUP;
                    if (f_op == OP_POLL) poll_count <= 16'd1;
`ifdef APB_TIMEOUT_EN
                    err    <= 1'b0;
`endif
                end
                ST_SETUP: begin
                    PENABLE <= 1'b1;
                    cnt     <= '0;
                    state   <= ST_ACCESS;
                end
                ST_ACCESS: if (PREADY) begin
                    PSEL      <= 1'b0;
                    PENABLE   <= 1'b0;
                    cnt       <= '0;
                    rsp_rdata <= PWRITE ? '0 : PRDATA;
                    state     <= (op == OP_POLL && !PRDATA[POLL_BIT]) ? ST_GAP : ST_RESP;
                end
`ifdef APB_TIMEOUT_EN
                else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                    PSEL      <= 1'b0;
                    PENABLE   <= 1'b0;
                    rsp_rdata <= '0;
                    err       <= 1'b1;
                    state     <= ST_RESP;
                end else cnt <= cnt + 1'b1;
`endif
                ST_GAP: if (cnt == CW'(POLL_GAP - 1)) begin
                    PSEL  <= 1'b1;
                    state <= ST_SETUP;
                    if (poll_count != 16'hFFFF) poll_count <= poll_count + 16'd1;
                end else cnt <= cnt + 1'b1;
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
